input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioning stage for every mechanical input feeding `engine` (power, mode switches, reverse/brake/clutch, direction buttons, middle). It synchronises each raw pin to `clk` and applies optional per-channel inversion. It then debounces each channel and produces clean levels, one-cycle press/release pulses, and long-press indications. `engine` and its mode sub-blocks (`man`, `semi_auto`, `auto`, `start`) consume these outputs instead of raw pins.

## Interface
- `N_CH`, default 12: number of conditioned channels.
- `DEBOUNCE_CYCLES`, default 2_000_000 (20 ms at 100 MHz): consecutive stable cycles needed to accept a change; must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 100_000_000 (1 s): cycles a level must stay high before long press; must be ≥ 2.
- `INVERT_MASK`, default all zeros: bit i = 1 inverts raw channel i before synchronisation (e.g. power switch).
- `clk  in  1`: 100 MHz system clock (P17); all logic on rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `raw  in  N_CH`: asynchronous pin inputs.
- `level  out  N_CH`: debounced state, 1 = active.
- `press_pulse  out  N_CH`: one-cycle pulse on each accepted 0→1 of `level`.
- `release_pulse  out  N_CH`: one-cycle pulse on each accepted 1→0 of `level`.
- `long_pulse  out  N_CH`: one-cycle pulse when `level` has been 1 for `LONG_PRESS_CYCLES`.
- `long_held  out  N_CH`: 1 from `long_pulse` until `level` falls.

## Operation
- Input path per channel: `raw ^ INVERT_MASK` → 2-flop synchroniser (`s1`, `s2`) → debounce counter → edge/long-press logic. Channels are fully independent.
- Debounce counter `dcnt`, width $clog2(DEBOUNCE_CYCLES):
  - Edge with `s2 == level`: `dcnt <= 0`.
  - Edge with `s2 != level` and `dcnt == DEBOUNCE_CYCLES-1`: `level <= s2`, `dcnt <= 0`, fire `press_pulse` or `release_pulse`.
  - Otherwise: `dcnt <= dcnt + 1`.
- Any single-cycle return of `s2` to `level` restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` never reach `level`.
- Long-press counter `lcnt`, width $clog2(LONG_PRESS_CYCLES):
  - Counts each edge while `level == 1` and `long_held == 0`.
  - At `lcnt == LONG_PRESS_CYCLES-1`: fire `long_pulse`, set `long_held`, hold `lcnt`.
  - The edge that lowers `level` clears `lcnt` and `long_held`.
- Long press fires at most once per press; there is no auto-repeat.
- Pulses are registered outputs and are never asserted for two consecutive cycles on one channel.
- Per-channel states are STABLE (`dcnt == 0`) and PENDING (`dcnt > 0`), plus the orthogonal `long_held` flag.

## Timing
- Reset (`reset_n == 0` at an edge) clears `s1`, `s2`, `level`, `dcnt`, `lcnt` and all outputs to 0. Reset dominates every other event.
- Reset mid-debounce or mid-long-press: the count is discarded and no pulse is emitted.
- After reset, an input already active at the pin is accepted like a fresh press. `press_pulse` fires `DEBOUNCE_CYCLES+1` edges after the first post-reset capture edge.
- Latency: if raw is stable from capture edge k (into `s1`), `level` and the pulse update at edge k+1+`DEBOUNCE_CYCLES`.
- `long_pulse` occurs `LONG_PRESS_CYCLES` edges after the edge that raised `level`.
- Release on the same edge `lcnt` would hit terminal: release wins, and there is no `long_pulse`.
- Counters never wrap: `dcnt` is bounded by the accept rule, and `lcnt` saturates.

## Structure
- Shared package `car_input_pkg`:
  - Channel index constants (`CH_POWER`, `CH_MODE0`, `CH_MODE1`, `CH_REVERSE`, `CH_BRAKE`, `CH_CLUTCH`, `CH_UP`, `CH_LEFT`, `CH_RIGHT`, `CH_DOWN`, `CH_MIDDLE`, `CH_MID_REV`).
  - Default `DEBOUNCE_CYCLES` / `LONG_PRESS_CYCLES`.
  - Default `INVERT_MASK`, with `CH_POWER` set.
- One sub-module `btn_debounce`, covering a single channel (synchroniser, `dcnt`, `lcnt`, pulses). The top instantiates it `N_CH` times with a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `LONG_PRESS_CYCLES=10`, `N_CH=2`.
- Clean press: ch0 raw 0→1 captured at edge 0. `level[0]` and `press_pulse[0]` go high after edge 5; the pulse lasts exactly 1 cycle. ch1 stays all-zero.
- Bounce: raw toggles 1,0,1,1,0 on successive cycles, then stays 1. `level` rises only 5 edges after the final 0→1 capture, with exactly one `press_pulse`.
- Long press: hold ch0 high. `long_pulse[0]` fires 10 edges after the `level` rise, and `long_held[0]` stays 1. Release: `release_pulse[0]`; `long_held[0]` and `level` fall on the same edge.
- Short press: `level` high for 6 cycles, then released. There is no `long_pulse`, and there is one `release_pulse`.
- Inversion: `INVERT_MASK=2'b10`, raw ch1 held 0 through reset release. `press_pulse[1]` fires 5 edges after the first post-reset capture.
- Reset mid-operation: assert `reset_n=0` with `dcnt=3` pending. All outputs are 0 next cycle, with no pulse. After reset deasserts, full latency is required again.

Source files
------------

// File: rtl/car_input_pkg.sv
// car_input_pkg
// Shared definitions for the mechanical-input front end feeding `engine`.
// Provides the channel index map, the default debounce / long-press
// timings for a 100 MHz clock, the default inversion mask (the power
// switch is wired active-low), and the per-channel debounce state type.
// No ports: package only.
package car_input_pkg;

  localparam int NUM_CHANNELS = 12;

  // Channel index map, matching the bit order of the `raw` pin bus.
  localparam int CH_POWER   = 0;
  localparam int CH_MODE0   = 1;
  localparam int CH_MODE1   = 2;
  localparam int CH_REVERSE = 3;
  localparam int CH_BRAKE   = 4;
  localparam int CH_CLUTCH  = 5;
  localparam int CH_UP      = 6;
  localparam int CH_LEFT    = 7;
  localparam int CH_RIGHT   = 8;
  localparam int CH_DOWN    = 9;
  localparam int CH_MIDDLE  = 10;
  localparam int CH_MID_REV = 11;

  // 20 ms and 1 s at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 2_000_000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 100_000_000;

  // The power switch pulls its pin low when on, so it is inverted by default.
  localparam logic [NUM_CHANNELS-1:0] DEFAULT_INVERT_MASK =
    NUM_CHANNELS'(1) << CH_POWER;

  // STABLE: no change pending (dcnt == 0). PENDING: s2 differs from level.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Conditions one mechanical input: optional inversion, 2-flop
// synchroniser, debounce counter, press/release edge pulses and a
// one-shot long-press indication.
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   raw           in   asynchronous pin level
//   level         out  debounced level, 1 = active
//   press_pulse   out  one-cycle pulse when level is accepted 0->1
//   release_pulse out  one-cycle pulse when level is accepted 1->0
//   long_pulse    out  one-cycle pulse when level has been 1 for LONG_PRESS_CYCLES
//   long_held     out  high from long_pulse until level falls
module btn_debounce
  import car_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit INVERT            = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_PRESS_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_next;
  logic [LW-1:0] lcnt;
  logic [LW-1:0] lcnt_next;
  logic          level_next;
  logic          press_next;
  logic          release_next;
  logic          long_next;
  logic          held_next;
  deb_state_e    state;

  assign state = (dcnt == '0) ? ST_STABLE : ST_PENDING;

  // Debounce: a change must be seen for DEBOUNCE_CYCLES consecutive edges.
  // Since DEBOUNCE_CYCLES >= 2, the terminal count is only ever reached
  // from PENDING, so STABLE simply starts the count.
  always_comb begin
    dcnt_next    = dcnt;
    level_next   = level;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      ST_STABLE: begin
        if (s2 != level) begin
          dcnt_next = DW'(1);
        end
      end
      ST_PENDING: begin
        if (s2 == level) begin
          dcnt_next = '0;
        end else if (dcnt == DCNT_LAST) begin
          dcnt_next    = '0;
          level_next   = s2;
          press_next   = s2;
          release_next = !s2;
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end
      default: begin
        dcnt_next = '0;
      end
    endcase
  end

  // Long press: count while level is held and no long press has fired yet.
  // An accepted release clears everything and pre-empts a long_pulse that
  // would otherwise fire on the same edge.
  always_comb begin
    lcnt_next = lcnt;
    long_next = 1'b0;
    held_next = long_held;
    if (!level || release_next) begin
      lcnt_next = '0;
      held_next = 1'b0;
    end else if (!long_held) begin
      if (lcnt == LCNT_LAST) begin
        long_next = 1'b1;
        held_next = 1'b1;
      end else begin
        lcnt_next = lcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      dcnt          <= '0;
      lcnt          <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      long_held     <= 1'b0;
    end else begin
      s1            <= raw ^ INVERT;
      s2            <= s1;
      dcnt          <= dcnt_next;
      lcnt          <= lcnt_next;
      level         <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_next;
      long_held     <= held_next;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Front-end conditioning for all mechanical inputs of `engine`. Each
// channel is handled by an independent btn_debounce instance.
// Ports:
//   clk           in   100 MHz system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   raw           in   [N_CH] asynchronous pin inputs
//   level         out  [N_CH] debounced levels
//   press_pulse   out  [N_CH] one-cycle accepted-press pulses
//   release_pulse out  [N_CH] one-cycle accepted-release pulses
//   long_pulse    out  [N_CH] one-cycle long-press pulses
//   long_held     out  [N_CH] long press active until release
module input_conditioner
  import car_input_pkg::*;
#(
  parameter int               N_CH              = NUM_CHANNELS,
  parameter int               DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int               LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter logic [N_CH-1:0]  INVERT_MASK       = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] long_held
);

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .INVERT            (INVERT_MASK[i])
    ) u_btn (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw           (raw[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .long_held     (long_held[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10,
// N_CH=2. Two instances: one without inversion, one with INVERT_MASK=2'b10.
// Each scenario row lists the raw waveform of ch0 (bit c = value captured
// at edge c), edges with reset asserted, and the hand-derived edges at which
// press, release and long press are expected.
module tb_input_conditioner;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] raw;
  logic [N-1:0] raw_inv;
  logic [N-1:0] level, press_pulse, release_pulse, long_pulse, long_held;
  logic [N-1:0] inv_level, inv_press, inv_release, inv_long, inv_held;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_CH (N), .DEBOUNCE_CYCLES (D), .LONG_PRESS_CYCLES (L), .INVERT_MASK (2'b00)
  ) dut (
    .clk (clk), .reset_n (reset_n), .raw (raw),
    .level (level), .press_pulse (press_pulse), .release_pulse (release_pulse),
    .long_pulse (long_pulse), .long_held (long_held)
  );

  input_conditioner #(
    .N_CH (N), .DEBOUNCE_CYCLES (D), .LONG_PRESS_CYCLES (L), .INVERT_MASK (2'b10)
  ) dut_inv (
    .clk (clk), .reset_n (reset_n), .raw (raw_inv),
    .level (inv_level), .press_pulse (inv_press), .release_pulse (inv_release),
    .long_pulse (inv_long), .long_held (inv_held)
  );

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] held;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] raw_bits;
    logic [31:0] rst_bits;
    int          n;
    int          press_at;
    int          release_at;
    int          long_at;
    bit          use_inv;
  } vec_t;

  vec_t  vecs[6];
  outs_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  // Drive one edge's inputs and push the outputs expected right after it.
  task automatic applyStimulus(input vec_t v, input int c);
    outs_t e;
    int    ch;
    ch      = v.use_inv ? 1 : 0;
    reset_n = ~v.rst_bits[c];
    raw     = {1'b0, v.raw_bits[c]};
    raw_inv = 2'b00;
    e       = '0;
    if (!v.rst_bits[c]) begin
      e.level[ch] = (c >= v.press_at) && (v.release_at < 0 || c < v.release_at);
      e.press[ch] = (c == v.press_at);
      e.rel[ch]   = (c == v.release_at);
      e.lng[ch]   = (c == v.long_at);
      e.held[ch]  = (v.long_at >= 0) && (c >= v.long_at) &&
                    (v.release_at < 0 || c < v.release_at);
    end
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input bit use_inv, input int c);
    outs_t act;
    outs_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s edge %0d: scoreboard empty", name, c);
      return;
    end
    e = exp_q.pop_front();
    if (use_inv) act = {inv_level, inv_press, inv_release, inv_long, inv_held};
    else         act = {level, press_pulse, release_pulse, long_pulse, long_held};
    if (act !== e) begin
      bad++;
      $display("[TB] FAIL %s edge %0d: got lvl=%b prs=%b rel=%b lng=%b hld=%b, want lvl=%b prs=%b rel=%b lng=%b hld=%b",
               name, c, act.level, act.press, act.rel, act.lng, act.held,
               e.level, e.press, e.rel, e.lng, e.held);
    end
  endtask

  // Two reset edges with pins idle; both instances must read all-zero.
  task automatic applyReset(input string name);
    reset_n = 1'b0;
    raw     = 2'b00;
    raw_inv = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    checkOutput({name, "_reset"}, 1'b0, -1);
    exp_q.push_back('0);
    checkOutput({name, "_reset_inv"}, 1'b1, -1);
  endtask

  initial begin
    // Clean press, long press after 10 edges, release with long_held.
    vecs[0] = '{"clean_long", 32'h000F_FFFF, 32'h0, 31, 5, 25, 15, 1'b0};
    // Bounce 1,0,1,1,0 then steady 1 from edge 5: press at 10.
    vecs[1] = '{"bounce", 32'h0007_FFED, 32'h0, 19, 10, -1, -1, 1'b0};
    // Level high for 6 cycles: no long press.
    vecs[2] = '{"short", 32'h0000_003F, 32'h0, 26, 5, 11, -1, 1'b0};
    // Release accepted on the edge lcnt hits terminal: release wins.
    vecs[3] = '{"release_race", 32'h0000_03FF, 32'h0, 26, 5, 15, -1, 1'b0};
    // Reset at edge 5 with dcnt=3 pending, full latency after reset.
    vecs[4] = '{"rst_pending", 32'hFFFF_FFFF, 32'h0000_0020, 15, 11, -1, -1, 1'b0};
    // Inverted ch1 with raw 0 through reset behaves as a fresh press.
    vecs[5] = '{"invert", 32'h0, 32'h0, 18, 5, -1, 15, 1'b1};

    for (int s = 0; s < 6; s++) begin
      applyReset(vecs[s].name);
      for (int c = 0; c < vecs[s].n; c++) begin
        applyStimulus(vecs[s], c);
        @(posedge clk);
        #1;
        checkOutput(vecs[s].name, vecs[s].use_inv, c);
      end
    end

    // Reset in the middle of a long press: level drops with no pulse and
    // no long press, then a fresh press needs full latency again.
    applyReset("rst_long");
    for (int c = 0; c < 22; c++) begin
      outs_t e;
      reset_n = (c != 12);
      raw     = 2'b01;
      raw_inv = 2'b00;
      e       = '0;
      if (c != 12) begin
        e.level[0] = ((c >= 5) && (c < 12)) || (c >= 18);
        e.press[0] = (c == 5) || (c == 18);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      checkOutput("rst_long", 1'b0, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
